// File: rtl/edge_param_loader.sv
// edge_param_loader: per-context bank of edge weight / boundary condition
// for a group of neighbour links. The bank is filled from a valid/ready word
// stream during the parameter-loading stage. The entry for the active context
// is presented to the links. The active context steps together with the
// links' context switch in the write-to-memory stage.
// Optional build macro: EDGE_PARAM_CHECKSUM_EN adds an XOR checksum of the
// raw accepted words. Without it, param_checksum is tied to zero.
// Stage codes are parameters so they can be overridden to match the global
// decoder encoding.
module edge_param_loader #(
  parameter int unsigned NUM_LINKS    = 4,
  parameter int unsigned NUM_CONTEXTS = 2,
  parameter int unsigned MAX_WEIGHT   = 2,
  parameter int unsigned STAGE_WIDTH  = 3,
  parameter logic [STAGE_WIDTH-1:0] STAGE_IDLE               = STAGE_WIDTH'(0),
  parameter logic [STAGE_WIDTH-1:0] STAGE_PARAMETERS_LOADING = STAGE_WIDTH'(1),
  parameter logic [STAGE_WIDTH-1:0] STAGE_WRITE_TO_MEM       = STAGE_WIDTH'(4),
  localparam int unsigned LBW    = $clog2(MAX_WEIGHT + 1),
  localparam int unsigned WORD_W = LBW + 2,
  localparam int unsigned CTX_W  = (NUM_CONTEXTS > 1) ? $clog2(NUM_CONTEXTS) : 1,
  localparam int unsigned LNK_W  = (NUM_LINKS > 1) ? $clog2(NUM_LINKS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [STAGE_WIDTH-1:0] global_stage,
  input  logic                   do_not_store,
  input  logic                   param_valid,
  input  logic [WORD_W-1:0]      param_data,
  output logic                   param_ready,
  output logic [NUM_LINKS*LBW-1:0] weight_out,
  output logic [NUM_LINKS*2-1:0] boundary_condition_out,
  output logic [CTX_W-1:0]       active_context,
  output logic                   load_done,
  output logic                   param_error,
  output logic [WORD_W-1:0]      param_checksum
);

  localparam logic [1:0] BND_NONE = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [STAGE_WIDTH-1:0] stage_q;
  logic                   ld_prev_q;
  logic                   stage_is_load;
  logic                   stage_is_wtm;

  logic                   param_ready_q, param_ready_d;
  logic                   load_done_q, load_done_d;
  logic                   param_error_q, param_error_d;
  logic [CTX_W-1:0]       act_q, act_d;
  logic [CTX_W-1:0]       wr_ctx_q, wr_ctx_d;
  logic [LNK_W-1:0]       wr_lnk_q, wr_lnk_d;

  logic                   load_entry_c;
  logic                   accept_c;
  logic                   last_word_c;
  logic                   over_c;
  logic [LBW-1:0]         raw_w_c;
  logic [1:0]             raw_b_c;
  logic [LBW-1:0]         san_w_c;

  logic [LBW-1:0]         w_bank_q [NUM_CONTEXTS][NUM_LINKS];
  logic [1:0]             b_bank_q [NUM_CONTEXTS][NUM_LINKS];

  logic [NUM_LINKS*LBW-1:0] weight_q;
  logic [NUM_LINKS*2-1:0]   bnd_q;

  assign stage_is_load = (stage_q == STAGE_PARAMETERS_LOADING);
  assign stage_is_wtm  = (stage_q == STAGE_WRITE_TO_MEM);
  assign accept_c      = param_ready_q & param_valid;
  assign last_word_c   = (wr_ctx_q == CTX_W'(NUM_CONTEXTS - 1)) &&
                         (wr_lnk_q == LNK_W'(NUM_LINKS - 1));

  // Registered copy of the global stage; all decisions use this copy.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q   <= STAGE_IDLE;
      ld_prev_q <= 1'b0;
    end else begin
      stage_q   <= global_stage;
      ld_prev_q <= stage_is_load;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state. DONE re-arms only on a fresh entry into the loading stage.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (stage_is_load) state_d = S_LOAD;
      S_LOAD: begin
        if (!stage_is_load)                state_d = S_IDLE;
        else if (accept_c && last_word_c)  state_d = S_DONE;
      end
      S_DONE: if (stage_is_load && !ld_prev_q) state_d = S_LOAD;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs. Ready is precomputed so the registered value is high exactly
  // while in LOAD with the loading stage active.
  always_comb begin
    load_entry_c  = (state_q != S_LOAD) && (state_d == S_LOAD);
    param_ready_d = (state_d == S_LOAD) && (global_stage == STAGE_PARAMETERS_LOADING);
    load_done_d   = load_done_q;
    if (load_entry_c)           load_done_d = 1'b0;
    else if (state_q == S_DONE) load_done_d = 1'b1;
  end

  // Word sanitising: non-existent edges carry weight 0, oversize weights saturate.
  always_comb begin
    raw_w_c = param_data[LBW-1:0];
    raw_b_c = param_data[LBW +: 2];
    over_c  = (raw_w_c > LBW'(MAX_WEIGHT));
    san_w_c = raw_w_c;
    if (raw_b_c == BND_NONE) san_w_c = '0;
    else if (over_c)         san_w_c = LBW'(MAX_WEIGHT);
  end

  // Next state for write pointers, sticky error and active context.
  always_comb begin
    wr_lnk_d      = wr_lnk_q;
    wr_ctx_d      = wr_ctx_q;
    param_error_d = param_error_q;
    act_d         = act_q;
    if (load_entry_c) begin
      wr_lnk_d      = '0;
      wr_ctx_d      = '0;
      param_error_d = 1'b0;
      act_d         = '0;
    end else begin
      if (accept_c) begin
        if (over_c) param_error_d = 1'b1;
        if (wr_lnk_q == LNK_W'(NUM_LINKS - 1)) begin
          wr_lnk_d = '0;
          wr_ctx_d = (wr_ctx_q == CTX_W'(NUM_CONTEXTS - 1)) ? '0 : wr_ctx_q + CTX_W'(1);
        end else begin
          wr_lnk_d = wr_lnk_q + LNK_W'(1);
        end
      end
      if (stage_is_wtm && !do_not_store && (NUM_CONTEXTS > 1)) begin
        act_d = (act_q == CTX_W'(NUM_CONTEXTS - 1)) ? '0 : act_q + CTX_W'(1);
      end
    end
  end

  // Control and pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      param_ready_q <= 1'b0;
      load_done_q   <= 1'b0;
      param_error_q <= 1'b0;
      act_q         <= '0;
      wr_lnk_q      <= '0;
      wr_ctx_q      <= '0;
    end else begin
      param_ready_q <= param_ready_d;
      load_done_q   <= load_done_d;
      param_error_q <= param_error_d;
      act_q         <= act_d;
      wr_lnk_q      <= wr_lnk_d;
      wr_ctx_q      <= wr_ctx_d;
    end
  end

  // Parameter bank; reset marks every link non-existent.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < int'(NUM_CONTEXTS); c++) begin
        for (int l = 0; l < int'(NUM_LINKS); l++) begin
          w_bank_q[c][l] <= '0;
          b_bank_q[c][l] <= BND_NONE;
        end
      end
    end else if (accept_c) begin
      w_bank_q[wr_ctx_q][wr_lnk_q] <= san_w_c;
      b_bank_q[wr_ctx_q][wr_lnk_q] <= raw_b_c;
    end
  end

  // Present the active-context bank entry to the links.
  always_ff @(posedge clk) begin
    if (reset) begin
      weight_q <= '0;
      bnd_q    <= {NUM_LINKS{BND_NONE}};
    end else begin
      for (int l = 0; l < int'(NUM_LINKS); l++) begin
        weight_q[l*LBW +: LBW] <= w_bank_q[act_q][l];
        bnd_q[l*2 +: 2]        <= b_bank_q[act_q][l];
      end
    end
  end

`ifdef EDGE_PARAM_CHECKSUM_EN
  logic [WORD_W-1:0] chk_q, chk_d;

  // XOR of raw accepted words, restarted on each load entry.
  always_comb begin
    chk_d = chk_q;
    if (load_entry_c)  chk_d = '0;
    else if (accept_c) chk_d = chk_q ^ param_data;
  end

  // Checksum register.
  always_ff @(posedge clk) begin
    if (reset) chk_q <= '0;
    else       chk_q <= chk_d;
  end

  assign param_checksum = chk_q;
`else
  assign param_checksum = '0;
`endif

  assign param_ready            = param_ready_q;
  assign load_done              = load_done_q;
  assign param_error            = param_error_q;
  assign active_context         = act_q;
  assign weight_out             = weight_q;
  assign boundary_condition_out = bnd_q;

endmodule

// File: tb/tb_edge_param_loader.sv
// Testbench for edge_param_loader with 2 links, 2 contexts and max weight 2.
module tb_edge_param_loader;

  localparam int NL   = 2;
  localparam int NC   = 2;
  localparam int MAXW = 2;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LD   = 3'd1;
  localparam logic [2:0] ST_WTM  = 3'd4;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] global_stage;
  logic       do_not_store;
  logic       param_valid;
  logic [3:0] param_data;
  logic       param_ready;
  logic [3:0] weight_out;
  logic [3:0] boundary_condition_out;
  logic [0:0] active_context;
  logic       load_done;
  logic       param_error;
  logic [3:0] param_checksum;

  edge_param_loader #(
    .NUM_LINKS(NL), .NUM_CONTEXTS(NC), .MAX_WEIGHT(MAXW), .STAGE_WIDTH(3),
    .STAGE_IDLE(ST_IDLE), .STAGE_PARAMETERS_LOADING(ST_LD), .STAGE_WRITE_TO_MEM(ST_WTM)
  ) dut (
    .clk(clk), .reset(reset), .global_stage(global_stage), .do_not_store(do_not_store),
    .param_valid(param_valid), .param_data(param_data), .param_ready(param_ready),
    .weight_out(weight_out), .boundary_condition_out(boundary_condition_out),
    .active_context(active_context), .load_done(load_done), .param_error(param_error),
    .param_checksum(param_checksum)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: phase 0=idle 1=loading 2=done, word counter k.
  int         m_phase, m_k, m_ctx;
  bit         m_left;
  logic [1:0] m_w [NC][NL];
  logic [1:0] m_b [NC][NL];
  logic [3:0] m_wout, m_bout, m_chk;
  logic       m_done, m_err;
  logic [2:0] m_stage;

  task automatic model_reset();
    m_phase = 0; m_k = 0; m_ctx = 0; m_left = 0;
    for (int c = 0; c < NC; c++)
      for (int l = 0; l < NL; l++) begin
        m_w[c][l] = 2'd0;
        m_b[c][l] = 2'b10;
      end
    m_wout = 4'b0000; m_bout = 4'b1010; m_chk = 4'h0;
    m_done = 1'b0; m_err = 1'b0; m_stage = ST_IDLE;
  endtask

  task automatic model_step(input logic [2:0] stg, input logic vld, input logic [3:0] dat,
                            input logic dns);
    bit ld, acc, entry, over;
    int nphase;
    logic [1:0] w, b;
    ld = (m_stage == ST_LD);
    acc = (m_phase == 1) && ld && vld;
    entry = 0;
    nphase = m_phase;
    case (m_phase)
      0: if (ld) begin nphase = 1; entry = 1; end
      1: if (!ld) nphase = 0; else if (acc && m_k == NL*NC-1) nphase = 2;
      default: if (ld && m_left) begin nphase = 1; entry = 1; end
    endcase
    for (int l = 0; l < NL; l++) begin
      m_wout[l*2 +: 2] = m_w[m_ctx][l];
      m_bout[l*2 +: 2] = m_b[m_ctx][l];
    end
    if (m_phase == 2 && !ld) m_left = 1;
    if (m_stage == ST_WTM && !dns) m_ctx = (m_ctx + 1) % NC;
    if (m_phase == 2) m_done = 1'b1;
    if (acc) begin
      w = dat[1:0];
      b = dat[3:2];
      over = (int'(w) > MAXW);
      if (b == 2'b10) w = 2'd0;
      else if (over)  w = 2'(MAXW);
      m_w[m_k / NL][m_k % NL] = w;
      m_b[m_k / NL][m_k % NL] = b;
      if (over) m_err = 1'b1;
      m_chk = m_chk ^ dat;
      m_k++;
    end
    if (entry) begin
      m_k = 0; m_left = 0; m_err = 1'b0; m_chk = 4'h0; m_done = 1'b0; m_ctx = 0;
    end
    m_phase = nphase;
    m_stage = stg;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".ready"}, 32'(param_ready), 32'(m_phase == 1 && m_stage == ST_LD));
    check({tag, ".done"},  32'(load_done), 32'(m_done));
    check({tag, ".err"},   32'(param_error), 32'(m_err));
    check({tag, ".ctx"},   32'(active_context), 32'(m_ctx));
    check({tag, ".wout"},  32'(weight_out), 32'(m_wout));
    check({tag, ".bout"},  32'(boundary_condition_out), 32'(m_bout));
`ifdef EDGE_PARAM_CHECKSUM_EN
    check({tag, ".chk"},   32'(param_checksum), 32'(m_chk));
`else
    check({tag, ".chk"},   32'(param_checksum), 32'h0);
`endif
  endtask

  task automatic cycle(input string tag, input logic [2:0] stg, input logic vld,
                       input logic [3:0] dat, input logic dns);
    global_stage = stg; param_valid = vld; param_data = dat; do_not_store = dns;
    @(posedge clk);
    model_step(stg, vld, dat, dns);
    #1;
    compare_all(tag);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    global_stage = ST_IDLE; param_valid = 1'b0; param_data = 4'h0; do_not_store = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    compare_all("reset");
  endtask

  typedef struct {
    logic [2:0] stg;
    logic       vld;
    logic [3:0] dat;
    logic       dns;
    logic       rdy;
    logic       done;
    logic       err;
    logic       ctx;
    logic [3:0] wout;
    logic [3:0] bout;
  } vec_t;

  vec_t tbl [21];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // stg vld dat dns | rdy done err ctx wout bout (values after the edge)
    tbl[0]  = '{ST_LD,   1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b1010};
    tbl[1]  = '{ST_LD,   1'b1, 4'h2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b1010};
    tbl[2]  = '{ST_LD,   1'b1, 4'h2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b1010};
    tbl[3]  = '{ST_LD,   1'b1, 4'h5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0010, 4'b1000};
    tbl[4]  = '{ST_LD,   1'b1, 4'h1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0110, 4'b0100};
    tbl[5]  = '{ST_LD,   1'b1, 4'hC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0110, 4'b0100};
    tbl[6]  = '{ST_LD,   1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0110, 4'b0100};
    tbl[7]  = '{ST_WTM,  1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0110, 4'b0100};
    tbl[8]  = '{ST_IDLE, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0110, 4'b0100};
    tbl[9]  = '{ST_IDLE, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0001, 4'b1100};
    tbl[10] = '{ST_WTM,  1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0001, 4'b1100};
    tbl[11] = '{ST_IDLE, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0001, 4'b1100};
    tbl[12] = '{ST_WTM,  1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0110, 4'b0100};
    tbl[13] = '{ST_IDLE, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0110, 4'b0100};
    tbl[14] = '{ST_IDLE, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0110, 4'b0100};
    tbl[15] = '{ST_LD,   1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0110, 4'b0100};
    tbl[16] = '{ST_LD,   1'b1, 4'h3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0110, 4'b0100};
    tbl[17] = '{ST_LD,   1'b1, 4'h3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0110, 4'b0100};
    tbl[18] = '{ST_LD,   1'b1, 4'h9, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0110, 4'b0100};
    tbl[19] = '{ST_IDLE, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0010, 4'b1000};
    tbl[20] = '{ST_IDLE, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0010, 4'b1000};

    // Reset followed by idle cycles.
    do_reset(3);
    repeat (5) cycle("idle", ST_IDLE, 1'b0, 4'h0, 1'b0);
    check("rst.wout",  32'(weight_out), 32'h0);
    check("rst.bout",  32'(boundary_condition_out), 32'hA);
    check("rst.ready", 32'(param_ready), 32'h0);
    check("rst.done",  32'(load_done), 32'h0);

    // Directed vector table: full load, context switching, saturation, abort.
    for (int i = 0; i < 21; i++) begin
      cycle("tbl", tbl[i].stg, tbl[i].vld, tbl[i].dat, tbl[i].dns);
      check($sformatf("tbl%0d.ready", i), 32'(param_ready), 32'(tbl[i].rdy));
      check($sformatf("tbl%0d.done", i),  32'(load_done), 32'(tbl[i].done));
      check($sformatf("tbl%0d.err", i),   32'(param_error), 32'(tbl[i].err));
      check($sformatf("tbl%0d.ctx", i),   32'(active_context), 32'(tbl[i].ctx));
      check($sformatf("tbl%0d.wout", i),  32'(weight_out), 32'(tbl[i].wout));
      check($sformatf("tbl%0d.bout", i),  32'(boundary_condition_out), 32'(tbl[i].bout));
      if (i == 6) begin
`ifdef EDGE_PARAM_CHECKSUM_EN
        check("tbl.checksum", 32'(param_checksum), 32'hA);
`else
        check("tbl.checksum", 32'(param_checksum), 32'h0);
`endif
      end
    end

    // Aborted load after reset: two words kept, context 1 stays non-existent.
    do_reset(2);
    cycle("abort", ST_IDLE, 1'b0, 4'h0, 1'b0);
    cycle("abort", ST_LD,   1'b0, 4'h0, 1'b0);
    cycle("abort", ST_LD,   1'b1, 4'h1, 1'b0);
    cycle("abort", ST_LD,   1'b1, 4'h1, 1'b0);
    cycle("abort", ST_LD,   1'b1, 4'h4, 1'b0);
    cycle("abort", ST_IDLE, 1'b0, 4'h0, 1'b0);
    cycle("abort", ST_IDLE, 1'b0, 4'h0, 1'b0);
    check("abort.done",  32'(load_done), 32'h0);
    check("abort.ready", 32'(param_ready), 32'h0);
    cycle("abort", ST_WTM,  1'b0, 4'h0, 1'b0);
    cycle("abort", ST_IDLE, 1'b0, 4'h0, 1'b0);
    cycle("abort", ST_IDLE, 1'b0, 4'h0, 1'b0);
    check("abort.ctx1",  32'(active_context), 32'h1);
    check("abort.bout1", 32'(boundary_condition_out), 32'hA);
    check("abort.wout1", 32'(weight_out), 32'h0);
    cycle("abort", ST_WTM,  1'b0, 4'h0, 1'b0);
    cycle("abort", ST_IDLE, 1'b0, 4'h0, 1'b0);
    cycle("abort", ST_IDLE, 1'b0, 4'h0, 1'b0);
    check("abort.wout0", 32'(weight_out), 32'h1);
    check("abort.bout0", 32'(boundary_condition_out), 32'h4);

    // Reset in the middle of a load discards the partial bank contents.
    cycle("midrst", ST_LD, 1'b0, 4'h0, 1'b0);
    cycle("midrst", ST_LD, 1'b1, 4'h5, 1'b0);
    cycle("midrst", ST_LD, 1'b1, 4'h5, 1'b0);
    do_reset(1);
    check("midrst.ready", 32'(param_ready), 32'h0);
    cycle("midrst", ST_IDLE, 1'b0, 4'h0, 1'b0);
    cycle("midrst", ST_IDLE, 1'b0, 4'h0, 1'b0);
    check("midrst.wout", 32'(weight_out), 32'h0);
    check("midrst.bout", 32'(boundary_condition_out), 32'hA);

    // Randomised stage runs, stream words and context pulses against the model.
    begin
      int run;
      int pick;
      logic [2:0] rs;
      run = 0;
      rs = ST_IDLE;
      for (int n = 0; n < 800; n++) begin
        if (run == 0) begin
          pick = $urandom_range(0, 9);
          if (pick < 5)      rs = ST_LD;
          else if (pick < 7) rs = ST_WTM;
          else               rs = 3'($urandom_range(0, 7));
          run = $urandom_range(1, 10);
        end
        run--;
        if ($urandom_range(0, 199) == 0) do_reset(1);
        else cycle("rand", rs, 1'($urandom_range(0, 3) != 0), 4'($urandom),
                   1'($urandom_range(0, 3) == 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
